// File: rtl/encoder_input_conditioner.sv
// Quadrature encoder pin conditioner: synchronises and glitch-filters A/B per channel,
// then classifies each filtered update as a step (with direction) or an illegal jump.
module encoder_input_conditioner #(
    parameter int CHANNELS      = 11,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [CHANNELS-1:0] enc_a_raw,
    input  logic [CHANNELS-1:0] enc_b_raw,
    output logic [CHANNELS-1:0] enc_a,
    output logic [CHANNELS-1:0] enc_b,
    output logic [CHANNELS-1:0] enc_step,
    output logic [CHANNELS-1:0] enc_dir,
    output logic [CHANNELS-1:0] enc_err,
    input  logic [CHANNELS-1:0] err_clr
);

    localparam int BITS = 2 * CHANNELS;
    localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [BITS-1:0]     sync_q [SYNC_STAGES];
    logic [BITS-1:0]     sync_s;
    logic [BITS-1:0]     filt_q;
    logic [BITS-1:0]     filt_d;
    logic [CNT_W-1:0]    cnt_q [BITS];
    logic [CNT_W-1:0]    cnt_d [BITS];

    logic [CHANNELS-1:0] a_prev;
    logic [CHANNELS-1:0] b_prev;
    logic [CHANNELS-1:0] a_next;
    logic [CHANNELS-1:0] b_next;
    logic [CHANNELS-1:0] a_chg;
    logic [CHANNELS-1:0] b_chg;
    logic [CHANNELS-1:0] fwd;
    logic [CHANNELS-1:0] armed_q;
    logic [CHANNELS-1:0] armed_d;
    logic [CHANNELS-1:0] step_d;
    logic [CHANNELS-1:0] err_set;
    logic [CHANNELS-1:0] dir_d;
    logic [CHANNELS-1:0] err_d;

    // A bits occupy the low half of every packed vector, B bits the high half.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {enc_b_raw, enc_a_raw};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < BITS; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign a_prev = filt_q[CHANNELS-1:0];
    assign b_prev = filt_q[BITS-1:CHANNELS];
    assign a_next = filt_d[CHANNELS-1:0];
    assign b_next = filt_d[BITS-1:CHANNELS];
    assign a_chg  = a_prev ^ a_next;
    assign b_chg  = b_prev ^ b_next;

    // Forward order 00->10->11->01->00: an A move is forward when new A differs
    // from B, a B move is forward when new B equals A.
    assign fwd     = (a_chg & (a_next ^ b_prev)) | (b_chg & ~(b_next ^ a_prev));
    assign step_d  = armed_q & (a_chg ^ b_chg);
    assign err_set = armed_q & a_chg & b_chg;
    assign dir_d   = (step_d & fwd) | (~step_d & enc_dir);
    assign err_d   = (enc_err & ~err_clr) | err_set;
    assign armed_d = armed_q | a_chg | b_chg;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            filt_q   <= '0;
            armed_q  <= '0;
            enc_step <= '0;
            enc_dir  <= '0;
            enc_err  <= '0;
            for (int i = 0; i < BITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q   <= filt_d;
            armed_q  <= armed_d;
            enc_step <= step_d;
            enc_dir  <= dir_d;
            enc_err  <= err_d;
            for (int i = 0; i < BITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign enc_a = a_prev;
    assign enc_b = b_prev;

endmodule

// File: tb/tb_encoder_input_conditioner.sv
// Bench for encoder_input_conditioner: directed scenarios plus random toggling, every
// cycle compared against a raw-history reference model of the filter and quadrature rules.
module tb_encoder_input_conditioner;

    localparam int C = 11;
    localparam int S = 2;
    localparam int F = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [C-1:0] a_raw = '0;
    logic [C-1:0] b_raw = '0;
    logic [C-1:0] err_clr = '0;
    logic [C-1:0] enc_a;
    logic [C-1:0] enc_b;
    logic [C-1:0] enc_step;
    logic [C-1:0] enc_dir;
    logic [C-1:0] enc_err;

    int checks = 0;
    int errors = 0;
    int step_cnt [C];
    int hi_cnt [C];

    bit [C-1:0] hist_a [$];
    bit [C-1:0] hist_b [$];
    bit [C-1:0] m_a, m_b, m_step, m_dir, m_err, m_armed;

    encoder_input_conditioner #(
        .CHANNELS(C), .SYNC_STAGES(S), .FILTER_CYCLES(F)
    ) dut (
        .clk_clk(clk),
        .reset_reset(reset),
        .enc_a_raw(a_raw),
        .enc_b_raw(b_raw),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enc_step(enc_step),
        .enc_dir(enc_dir),
        .enc_err(enc_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Quadrature position along the forward cycle 00,10,11,01.
    function automatic int gpos(bit a, bit b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic modelReset();
        hist_a.delete();
        hist_b.delete();
        repeat (S + F) begin
            hist_a.push_back('0);
            hist_b.push_back('0);
        end
        m_a = '0; m_b = '0; m_step = '0; m_dir = '0; m_err = '0; m_armed = '0;
    endtask

    // hist[0] is the raw sample of this edge; entries S..S+F-1 are the synchronised
    // levels of the last F cycles. An output flips once all of them disagree with it.
    task automatic modelStep();
        bit [C-1:0] na, nb, eset;
        bit flip_a, flip_b;
        int d;
        if (reset) begin
            modelReset();
            return;
        end
        hist_a.push_front(a_raw);
        hist_b.push_front(b_raw);
        void'(hist_a.pop_back());
        void'(hist_b.pop_back());
        na = m_a;
        nb = m_b;
        eset = '0;
        m_step = '0;
        for (int ch = 0; ch < C; ch++) begin
            flip_a = 1'b1;
            flip_b = 1'b1;
            for (int k = S; k < S + F; k++) begin
                if (hist_a[k][ch] == m_a[ch]) flip_a = 1'b0;
                if (hist_b[k][ch] == m_b[ch]) flip_b = 1'b0;
            end
            if (flip_a) na[ch] = ~m_a[ch];
            if (flip_b) nb[ch] = ~m_b[ch];
            d = (gpos(na[ch], nb[ch]) - gpos(m_a[ch], m_b[ch]) + 4) % 4;
            if (m_armed[ch]) begin
                if (d == 1) begin m_step[ch] = 1'b1; m_dir[ch] = 1'b1; end
                else if (d == 3) begin m_step[ch] = 1'b1; m_dir[ch] = 1'b0; end
                else if (d == 2) eset[ch] = 1'b1;
            end
            if (d != 0) m_armed[ch] = 1'b1;
        end
        m_err = (m_err & ~err_clr) | eset;
        m_a = na;
        m_b = nb;
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            modelStep();
            checkOutput("enc_a", 32'(enc_a), 32'(m_a));
            checkOutput("enc_b", 32'(enc_b), 32'(m_b));
            checkOutput("enc_step", 32'(enc_step), 32'(m_step));
            checkOutput("enc_dir", 32'(enc_dir), 32'(m_dir));
            checkOutput("enc_err", 32'(enc_err), 32'(m_err));
            for (int ch = 0; ch < C; ch++) begin
                step_cnt[ch] += int'(enc_step[ch]);
                hi_cnt[ch]   += int'(enc_a[ch]);
            end
        end
    endtask

    task automatic waitRise(input int ch, input int exp_edges);
        int n = 0;
        while (n < 20 && enc_a[ch] !== 1'b1) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("rise_latency", 32'(n), 32'(exp_edges));
    endtask

    initial begin
        int timer [C];
        int r;
        modelReset();
        foreach (step_cnt[i]) begin step_cnt[i] = 0; hi_cnt[i] = 0; end
        applyStimulus(2);
        reset = 1'b0;

        $display("[TB] first rise after reset");
        a_raw[0] = 1'b1;
        waitRise(0, S + F);
        applyStimulus(3);
        checkOutput("first_rise_step", 32'(step_cnt[0]), 32'd0);
        checkOutput("first_rise_err", 32'(enc_err), 32'd0);

        $display("[TB] forward and reverse steps on channel 3");
        a_raw[3] = 1'b1; applyStimulus(10);
        a_raw[3] = 1'b0; applyStimulus(10);
        step_cnt[3] = 0;
        a_raw[3] = 1'b1; applyStimulus(10);
        b_raw[3] = 1'b1; applyStimulus(10);
        a_raw[3] = 1'b0; applyStimulus(10);
        b_raw[3] = 1'b0; applyStimulus(10);
        checkOutput("fwd_steps", 32'(step_cnt[3]), 32'd4);
        checkOutput("fwd_dir", 32'(enc_dir[3]), 32'd1);
        step_cnt[3] = 0;
        b_raw[3] = 1'b1; applyStimulus(10);
        a_raw[3] = 1'b1; applyStimulus(10);
        b_raw[3] = 1'b0; applyStimulus(10);
        a_raw[3] = 1'b0; applyStimulus(10);
        checkOutput("rev_steps", 32'(step_cnt[3]), 32'd4);
        checkOutput("rev_dir", 32'(enc_dir[3]), 32'd0);

        $display("[TB] glitch rejection on channel 5");
        a_raw[5] = 1'b1; applyStimulus(10);
        a_raw[5] = 1'b0; applyStimulus(10);
        hi_cnt[5] = 0; step_cnt[5] = 0;
        a_raw[5] = 1'b1; applyStimulus(3);
        a_raw[5] = 1'b0; applyStimulus(12);
        checkOutput("glitch3_high", 32'(hi_cnt[5]), 32'd0);
        checkOutput("glitch3_step", 32'(step_cnt[5]), 32'd0);
        a_raw[5] = 1'b1; applyStimulus(4);
        a_raw[5] = 1'b0; applyStimulus(12);
        checkOutput("pulse4_high", 32'(hi_cnt[5]), 32'd4);
        checkOutput("pulse4_step", 32'(step_cnt[5]), 32'd2);

        $display("[TB] illegal transition on channel 7");
        b_raw[7] = 1'b1; applyStimulus(10);
        b_raw[7] = 1'b0; applyStimulus(10);
        step_cnt[7] = 0;
        a_raw[7] = 1'b1; b_raw[7] = 1'b1; applyStimulus(10);
        checkOutput("err_set", 32'(enc_err[7]), 32'd1);
        checkOutput("err_dir_held", 32'(enc_dir[7]), 32'd1);
        checkOutput("err_no_step", 32'(step_cnt[7]), 32'd0);
        checkOutput("err_ab", 32'({enc_a[7], enc_b[7]}), 32'd3);
        err_clr[7] = 1'b1; applyStimulus(1);
        err_clr[7] = 1'b0;
        checkOutput("err_clear", 32'(enc_err[7]), 32'd0);
        a_raw[7] = 1'b0; b_raw[7] = 1'b0; applyStimulus(S + F - 1);
        err_clr[7] = 1'b1; applyStimulus(1);
        err_clr[7] = 1'b0;
        checkOutput("err_set_wins", 32'(enc_err[7]), 32'd1);
        checkOutput("err_ab_back", 32'({enc_a[7], enc_b[7]}), 32'd0);

        $display("[TB] random toggling on all channels");
        foreach (timer[i]) timer[i] = $urandom_range(0, 8);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int ch = 0; ch < C; ch++) begin
                if (timer[ch] == 0) begin
                    r = $urandom_range(0, 9);
                    if (r < 4) a_raw[ch] = ~a_raw[ch];
                    else if (r < 8) b_raw[ch] = ~b_raw[ch];
                    else if (r == 8) begin a_raw[ch] = ~a_raw[ch]; b_raw[ch] = ~b_raw[ch]; end
                    timer[ch] = $urandom_range(4, 12);
                end else begin
                    timer[ch]--;
                end
            end
            err_clr = ($urandom_range(0, 7) == 0) ? C'($urandom) : '0;
            applyStimulus(1);
        end
        err_clr = '0;

        $display("[TB] reset during filter count on channel 2");
        a_raw = '0; b_raw = '0;
        applyStimulus(12);
        a_raw[2] = 1'b1;
        applyStimulus(4);
        reset = 1'b1; applyStimulus(1);
        reset = 1'b0;
        checkOutput("reset_outputs", 32'(enc_a | enc_b | enc_step | enc_dir | enc_err), 32'd0);
        waitRise(2, S + F);
        applyStimulus(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
